// File: rtl/edge_pixel_postproc_if.sv
// ---------------------------------------------------------------------------
// edge_pixel_postproc_if
// Stream bundle around the edge post-processing stage.
//   Input side : in_valid, in_data (signed, IN_W bits), threshold, bin_mode
//   Output side: out_valid/out_ready handshake, out_pixel, framing tags
//                out_sol / out_eol / out_eof
// Modports:
//   master - the environment: drives samples in and consumes pixels out
//   slave  - the post-processing block itself
// ---------------------------------------------------------------------------
interface edge_pixel_postproc_if #(
    parameter int IN_W = 13
);
    logic                   in_valid;
    logic signed [IN_W-1:0] in_data;
    logic        [7:0]      threshold;
    logic                   bin_mode;

    logic                   out_valid;
    logic                   out_ready;
    logic        [7:0]      out_pixel;
    logic                   out_sol;
    logic                   out_eol;
    logic                   out_eof;

    modport master (
        output in_valid, in_data, threshold, bin_mode, out_ready,
        input  out_valid, out_pixel, out_sol, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_data, threshold, bin_mode, out_ready,
        output out_valid, out_pixel, out_sol, out_eol, out_eof
    );
endinterface

// File: rtl/edge_pixel_postproc.sv
// ---------------------------------------------------------------------------
// edge_pixel_postproc
// Post-processing behind the Laplacian convolution core. Each qualified
// signed sum is turned into |E| saturated to 8 bits, optionally binarised
// against a threshold, tagged with row/column framing for an OUT_W x OUT_H
// image and queued in a small FIFO, because the core upstream cannot stall.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-low reset
//   bus        - edge_pixel_postproc_if.slave (sample in, pixel stream out)
//   frame_done - one-cycle pulse the cycle after the eof pixel is popped
//   overflow   - sticky; a stage-1 result was dropped on a full FIFO
// ---------------------------------------------------------------------------
module edge_pixel_postproc #(
    parameter int OUT_W      = 126,
    parameter int OUT_H      = 126,
    parameter int IN_W       = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    edge_pixel_postproc_if.slave        bus,
    output logic                        frame_done,
    output logic                        overflow
);
    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    // Entry layout: {pix[7:0], sol, eol, eof}
    localparam int EW = 11;

    // ------------------------------------------------------------------
    // Framing counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic          at_sol;
    logic          at_eol;
    logic          at_eof;

    assign at_sol = (col_reg == '0);
    assign at_eol = (col_reg == CW'(OUT_W - 1));
    assign at_eof = at_eol && (row_reg == RW'(OUT_H - 1));

    // ------------------------------------------------------------------
    // Magnitude, saturation, binarisation
    // ------------------------------------------------------------------
    logic [IN_W-1:0] mag;
    logic [7:0]      sat;
    logic [7:0]      pix;

    always_comb begin
        // Two's-complement negate in IN_W bits; the most negative input
        // lands on 2^(IN_W-1) when read as unsigned, which is the true |x|.
        mag = bus.in_data[IN_W-1] ? ((~bus.in_data) + IN_W'(1)) : bus.in_data;
        sat = (mag > IN_W'(255)) ? 8'hFF : mag[7:0];
        pix = bus.bin_mode ? ((sat >= bus.threshold) ? 8'hFF : 8'h00) : sat;
    end

    // ------------------------------------------------------------------
    // Stage 1 register and counters
    // ------------------------------------------------------------------
    logic          s1_valid_reg;
    logic [EW-1:0] s1_entry_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_entry_reg <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
        end else begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_entry_reg <= {pix, at_sol, at_eol, at_eof};
                // Counters track every sample, dropped or not, so the
                // geometry of later pixels stays correct.
                if (at_eol) begin
                    col_reg <= '0;
                    row_reg <= at_eof ? '0 : row_reg + RW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: pointers carry one extra wrap bit for full/empty
    // ------------------------------------------------------------------
    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_en;
    logic          drop;
    logic          overflow_reg;
    logic          frame_done_reg;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign pop     = !empty && bus.out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push_en = s1_valid_reg && (!full || pop);
    assign drop    = s1_valid_reg && full && !pop;
    assign head    = mem[rd_ptr_reg[PW-1:0]];

    // Storage has no reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[PW-1:0]] <= s1_entry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            frame_done_reg <= pop && head[0];
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_pixel = empty ? 8'h00 : head[10:3];
    assign bus.out_sol   = !empty && head[2];
    assign bus.out_eol   = !empty && head[1];
    assign bus.out_eof   = !empty && head[0];
    assign frame_done    = frame_done_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_edge_pixel_postproc.sv
module tb_edge_pixel_postproc;
    localparam int OUT_W      = 126;
    localparam int OUT_H      = 126;
    localparam int IN_W       = 13;
    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_done;
    logic overflow;

    always #5 clk = ~clk;

    edge_pixel_postproc_if #(.IN_W(IN_W)) bus ();

    edge_pixel_postproc #(
        .OUT_W(OUT_W), .OUT_H(OUT_H), .IN_W(IN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic [7:0] pix;
        logic       sol;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_col = 0;
    int   m_row = 0;
    int   pop_count = 0;
    int   fd_count = 0;
    int   eof_count = 0;
    logic fd_expect = 1'b0;

    function automatic logic [7:0] model_pix(int v, bit bm, int thr);
        int mag;
        int sat;
        mag = (v < 0) ? -v : v;
        sat = (mag > 255) ? 255 : mag;
        if (bm) return (sat >= thr) ? 8'hFF : 8'h00;
        return 8'(sat);
    endfunction

    // Scoreboard monitor: compares every popped pixel and the frame_done pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (reset === 1'b1) begin
            checks++;
            if (frame_done !== fd_expect) begin
                errors++;
                $display("FAIL frame_done got %b expected %b at %0t", frame_done, fd_expect, $time);
            end
            if (frame_done === 1'b1) fd_count++;
            fd_expect = 1'b0;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                pop_count++;
                checks++;
                got = {bus.out_pixel, bus.out_sol, bus.out_eol, bus.out_eof};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop got pix=%0d sol=%b eol=%b eof=%b at %0t",
                             got.pix, got.sol, got.eol, got.eof, $time);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL pixel got pix=%0d sol=%b eol=%b eof=%b expected pix=%0d sol=%b eol=%b eof=%b at %0t",
                                 got.pix, got.sol, got.eol, got.eof, e.pix, e.sol, e.eol, e.eof, $time);
                    end
                    if (got.eof === 1'b1) eof_count++;
                    fd_expect = e.eof;
                end
            end
        end else begin
            fd_expect = 1'b0;
        end
    end

    task automatic send(int v, bit bm, int thr, bit keep);
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_data   = IN_W'(v);
        bus.bin_mode  = bm;
        bus.threshold = 8'(thr);
        e.pix = model_pix(v, bm, thr);
        e.sol = (m_col == 0);
        e.eol = (m_col == OUT_W - 1);
        e.eof = e.eol && (m_row == OUT_H - 1);
        if (keep) sb.push_back(e);
        if (m_col == OUT_W - 1) begin
            m_col = 0;
            m_row = (m_row == OUT_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while ((sb.size() != 0 || bus.out_valid === 1'b1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout got %0d left expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        m_col = 0;
        m_row = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
        if (bus.out_pixel !== 8'h00) begin errors++; $display("FAIL reset_out_pixel got %0d expected 0", bus.out_pixel); end
        if (bus.out_sol !== 1'b0) begin errors++; $display("FAIL reset_out_sol got %b expected 0", bus.out_sol); end
        if (bus.out_eol !== 1'b0) begin errors++; $display("FAIL reset_out_eol got %b expected 0", bus.out_eol); end
        if (bus.out_eof !== 1'b0) begin errors++; $display("FAIL reset_out_eof got %b expected 0", bus.out_eof); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b expected 0", frame_done); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
        reset = 1'b1;
        m_col = 0;
        m_row = 0;
    endtask

    task automatic test_grey();
        bus.out_ready = 1'b1;
        send(100, 1'b0, 0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got out_valid=%b expected 0", bus.out_valid); end
        send(-100, 1'b0, 0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_2cyc got out_valid=%b expected 1", bus.out_valid); end
        send(300, 1'b0, 0, 1'b1);
        send(-4096, 1'b0, 0, 1'b1);
        send(0, 1'b0, 0, 1'b1);
        wait_drain();
    endtask

    task automatic test_binary();
        bus.out_ready = 1'b1;
        send(49, 1'b1, 50, 1'b1);
        send(50, 1'b1, 50, 1'b1);
        send(-51, 1'b1, 50, 1'b1);
        wait_drain();
    endtask

    task automatic test_frame();
        int v;
        do_reset();
        bus.out_ready = 1'b1;
        fd_count  = 0;
        eof_count = 0;
        for (int i = 0; i < OUT_W * OUT_H; i++) begin
            if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 600)) - 300;
            else v = int'($urandom_range(0, 8191)) - 4096;
            send(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b1);
        end
        send(7, 1'b0, 0, 1'b1);  // first pixel of the next frame: sol expected
        wait_drain();
        idle(2);
        checks += 2;
        if (fd_count !== 1) begin errors++; $display("FAIL frame_done_count got %0d expected 1", fd_count); end
        if (eof_count !== 1) begin errors++; $display("FAIL eof_count got %0d expected 1", eof_count); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] head_exp;
        bus.out_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) send(20 * i + 3, 1'b0, 0, 1'b1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        head_exp = sb[0].pix;
        checks += 3;
        if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow got %b expected 0", overflow); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pushpop_valid got %b expected 1", bus.out_valid); end
        if (bus.out_pixel !== head_exp) begin errors++; $display("FAIL pushpop_head got %0d expected %0d", bus.out_pixel, head_exp); end
        idle(2);
        checks++;
        if (bus.out_pixel !== head_exp) begin errors++; $display("FAIL pushpop_hold got %0d expected %0d", bus.out_pixel, head_exp); end
        pop_count = 0;
        bus.out_ready = 1'b1;
        wait_drain();
        checks += 2;
        if (pop_count !== FIFO_DEPTH) begin errors++; $display("FAIL pushpop_occupancy got %0d expected %0d", pop_count, FIFO_DEPTH); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow_end got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [7:0] head_exp;
        bus.out_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) send(11 * i + 1, 1'b0, 0, 1'b1);
        send(200, 1'b0, 0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got %b expected 0", overflow); end
        send(201, 1'b0, 0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b expected 1", overflow); end
        idle(1);
        head_exp = sb[0].pix;
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL overflow_valid got %b expected 1", bus.out_valid); end
        if (bus.out_pixel !== head_exp) begin errors++; $display("FAIL overflow_head got %0d expected %0d", bus.out_pixel, head_exp); end
        idle(3);
        checks++;
        if (bus.out_pixel !== head_exp) begin errors++; $display("FAIL overflow_hold got %0d expected %0d", bus.out_pixel, head_exp); end
        pop_count = 0;
        bus.out_ready = 1'b1;
        wait_drain();
        checks += 2;
        if (pop_count !== FIFO_DEPTH) begin errors++; $display("FAIL overflow_drain got %0d expected %0d", pop_count, FIFO_DEPTH); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b expected 1", overflow); end
    endtask

    task automatic test_reset_midframe();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 297; i++) send((i * 37) % 500 - 250, 1'b0, 0, 1'b1);
        wait_drain();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(60 + i, 1'b0, 0, 1'b1);
        idle(2);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midframe_buffered got %b expected 1", bus.out_valid); end
        do_reset();
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midframe_valid got %b expected 0", bus.out_valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL midframe_overflow got %b expected 0", overflow); end
        if (bus.out_pixel !== 8'h00) begin errors++; $display("FAIL midframe_pixel got %0d expected 0", bus.out_pixel); end
        bus.out_ready = 1'b1;
        send(90, 1'b0, 0, 1'b1);
        idle(1);
        checks++;
        if (bus.out_sol !== 1'b1) begin errors++; $display("FAIL midframe_sol got %b expected 1", bus.out_sol); end
        wait_drain();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.threshold = 8'd0;
        bus.bin_mode  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_grey();
        test_binary();
        test_frame();
        test_full_pushpop();
        test_overflow();
        test_reset_midframe();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL leftover got %0d expected 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/edge_pixel_postproc.md
Name: edge_pixel_postproc

Overview:
Downstream stage of the 3-channel Laplacian convolution core. Consumes the signed 13-bit per-pixel sum stream (E qualified by Save), forms magnitude, saturates to 8 bits, and optionally binarises against a programmable threshold. Tags each pixel with row/column framing for the 126x126 output image. Buffers results in a small FIFO behind a valid/ready interface, because the convolution core cannot be stalled.

Parameters:
OUT_W, 126, output image width in pixels (IMAGE_WIDTH-FILTER_WIDTH+1)
OUT_H, 126, output image height in pixels
IN_W, 13, input sample width (signed)
FIFO_DEPTH, 8, output FIFO entries; power of 2, >=2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  sample qualifier (Save of convolution core); one sample per cycle while high
in_data  input  IN_W  signed convolution sum (E)
threshold  input  8  binarisation threshold, sampled with each accepted sample
bin_mode  input  1  1 = binary edge map, 0 = grey magnitude; sampled per sample
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head when high with out_valid
out_pixel  output  8  processed pixel
out_sol  output  1  head is column 0 (start of line)
out_eol  output  1  head is column OUT_W-1
out_eof  output  1  head is last pixel of frame (row OUT_H-1, col OUT_W-1)
frame_done  output  1  one-cycle pulse when the eof pixel is popped
overflow  output  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- One clock, clk. reset is synchronous and active-low: sampled only on the rising edge of clk; while low, all state is cleared.
- Reset values: out_valid=0, out_pixel=0, out_sol/out_eol/out_eof=0, frame_done=0, overflow=0. Reset also zeroes the col/row counters, empties the FIFO, and clears the stage-1 register.
- Reset mid-frame discards all buffered pixels. The next accepted sample is col 0, row 0.
- Stage 1 (registered), updated on any cycle with in_valid=1:
  - mag = |in_data|, with |-4096| = 4096.
  - sat = (mag > 255) ? 255 : mag[7:0].
  - pix = bin_mode ? ((sat >= threshold) ? 8'hFF : 8'h00) : sat.
  - Tags: sol = (col==0); eol = (col==OUT_W-1); eof = eol && (row==OUT_H-1).
- Counters:
  - col increments on each accepted sample.
  - At OUT_W-1, col wraps to 0 and row increments.
  - At the eof sample, row and col both wrap to 0, so back-to-back frames need no re-arm.
  - Counters advance even when the sample is dropped, which preserves frame geometry.
- Stage 2: the stage-1 result {pix, sol, eol, eof} is pushed into the FIFO on the cycle after stage-1 capture.
- Latency: sample on edge N -> FIFO write at edge N+1 -> out_valid high after edge N+1 when the FIFO was empty. First-word latency is 2 cycles. Sustained throughput is 1 pixel/cycle when out_ready is held at 1.
- FIFO:
  - out_valid = not empty; head fields are driven directly from FIFO storage.
  - Pop on out_valid && out_ready.
  - Push allowed when not full, or when full and a pop occurs in the same cycle (simultaneous push and pop when full leaves the occupancy unchanged).
  - Push while full without a pop: the entry is discarded and overflow is set to 1. overflow stays 1 until reset.
  - Simultaneous push and pop when empty is not bypassed; out_valid rises the following cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH, with one extra bit for the full/empty distinction.
- Downstream rule: out_pixel and tags are held stable while out_valid=1 and out_ready=0.
- frame_done is registered: it goes high the cycle after the pop of an entry with eof=1, for exactly one cycle.
- in_valid=0 bubbles create no FIFO entries and do not advance the counters.

Test Plan:
- Reset, then in_valid=1 with in_data = +100, -100, +300, -4096, 0 in consecutive cycles, bin_mode=0, out_ready=1 -> out_pixel = 100, 100, 255, 255, 0; first out_valid 2 cycles after the first sample.
- bin_mode=1, threshold=50, inputs 49, 50, -51 -> out_pixel = 0x00, 0xFF, 0xFF.
- Full frame of 126*126 samples, out_ready=1:
  - out_sol on pixels 0, 126, 252, ...
  - out_eol on pixels 125, 251, ...
  - out_eof only on pixel 15875.
  - frame_done pulses once, the cycle after that pop.
  - The next sample has out_sol=1 and row 0.
- out_ready=0 with 10 samples, FIFO_DEPTH=8:
  - 8 entries are held with out_valid=1 and the head stable.
  - overflow=1 after the 9th push attempt.
  - Raising out_ready drains exactly 8 pixels in order.
- FIFO full, out_ready=1 and in_valid=1 in the same cycle -> no drop, overflow stays 0, occupancy unchanged.
- Assert reset low for 1 cycle after 300 samples with 3 buffered -> out_valid=0 the next cycle, overflow=0; the next sample is tagged out_sol=1, row 0.
